// File: rtl/perf_snapshot.sv
// perf_snapshot: scans a bank of performance counters on request and streams
// {index, value, last} entries out through a small valid/ready FIFO.
// Counters can optionally be cleared as they are read.
module perf_snapshot #(
   parameter int unsigned NR_COUNTERS = 14,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        trigger_i,
   input  logic        clear_on_read_i,
   output logic        busy_o,
   output logic        trig_dropped_o,
   output logic [11:0] perf_addr_o,
   output logic        perf_we_o,
   output logic [63:0] perf_data_o,
   input  logic [63:0] perf_data_i,
   output logic        snap_valid_o,
   input  logic        snap_ready_i,
   output logic [3:0]  snap_idx_o,
   output logic [63:0] snap_data_o,
   output logic        snap_last_o
);

   localparam int unsigned IDX_W  = 4;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned ADDR_W = 12;
   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_COUNTERS - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } state_e;

   typedef struct packed {
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] data;
      logic              last;
   } entry_t;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               clr_q, clr_d;
   logic               drop_q, drop_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   entry_t             fifo_q [FIFO_DEPTH];
   entry_t             push_entry;
   entry_t             head;
   logic               push, pop, full, empty;

   // Fullness is judged on the registered count so a same-cycle pop never frees a slot for a push.
   assign full  = (cnt_q == FULL_CNT);
   assign empty = (cnt_q == '0);
   assign pop   = !rst_i && !empty && snap_ready_i;

   // Next-state logic for the scan FSM and the counter-port drive.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      clr_d       = clr_q;
      drop_d      = drop_q;
      push        = 1'b0;
      perf_addr_o = '0;
      perf_we_o   = 1'b0;
      perf_data_o = '0;
      push_entry  = '{idx: idx_q, data: perf_data_i, last: (idx_q == LAST_IDX)};
      unique case (state_q)
         IDLE: begin
            if (trigger_i) begin
               state_d = SCAN;
               idx_d   = '0;
               clr_d   = clear_on_read_i;
               drop_d  = 1'b0;
            end
         end
         SCAN: begin
            perf_addr_o = ADDR_W'(idx_q);
            if (trigger_i) drop_d = 1'b1;
            if (!full) begin
               push      = 1'b1;
               perf_we_o = clr_q;
               idx_d     = idx_q + IDX_W'(1);
               if (idx_q == LAST_IDX) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (trigger_i) drop_d = 1'b1;
            if (empty || (cnt_q == ONE_CNT && pop)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (rst_i) begin
         push        = 1'b0;
         perf_addr_o = '0;
         perf_we_o   = 1'b0;
      end
   end

   // FIFO pointer and occupancy bookkeeping.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + ONE_CNT;
         2'b01:   cnt_d = cnt_q - ONE_CNT;
         default: cnt_d = cnt_q;
      endcase
   end

   // Control registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         clr_q    <= 1'b0;
         drop_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         clr_q    <= clr_d;
         drop_q   <= drop_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // FIFO storage; contents are don't-care while empty so no reset is needed.
   always_ff @(posedge clk_i) begin
      if (push) fifo_q[wr_ptr_q] <= push_entry;
   end

   assign head           = fifo_q[rd_ptr_q];
   assign busy_o         = (state_q != IDLE) && !rst_i;
   assign trig_dropped_o = drop_q;
   assign snap_valid_o   = !empty && !rst_i;
   assign snap_idx_o     = head.idx;
   assign snap_data_o    = head.data;
   assign snap_last_o    = head.last;

endmodule

// File: tb/tb_perf_snapshot.sv
// Directed bench for perf_snapshot with a behavioural counter bank and stream monitor.
module tb_perf_snapshot;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        trigger = 1'b0;
   logic        clear = 1'b0;
   logic        busy_o, trig_dropped_o, perf_we_o;
   logic [11:0] perf_addr_o;
   logic [63:0] perf_data_o, perf_data_i;
   logic        snap_valid_o;
   logic        snap_ready = 1'b1;
   logic [3:0]  snap_idx_o;
   logic [63:0] snap_data_o;
   logic        snap_last_o;

   int n_cmp  = 0;
   int n_fail = 0;

   // Counter bank model: combinational read, write on the rising edge.
   logic [63:0] cnt [16];
   logic        load_req = 1'b0;
   logic [63:0] load_base = '0;

   logic [3:0]  rx_idx  [$];
   logic [63:0] rx_data [$];
   logic        rx_last [$];
   logic [11:0] wr_addr [$];
   logic        wr_nonzero = 1'b0;

   perf_snapshot #(.NR_COUNTERS(14), .FIFO_DEPTH(4)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .trigger_i       (trigger),
      .clear_on_read_i (clear),
      .busy_o          (busy_o),
      .trig_dropped_o  (trig_dropped_o),
      .perf_addr_o     (perf_addr_o),
      .perf_we_o       (perf_we_o),
      .perf_data_o     (perf_data_o),
      .perf_data_i     (perf_data_i),
      .snap_valid_o    (snap_valid_o),
      .snap_ready_i    (snap_ready),
      .snap_idx_o      (snap_idx_o),
      .snap_data_o     (snap_data_o),
      .snap_last_o     (snap_last_o)
   );

   always #5 clk = ~clk;

   assign perf_data_i = cnt[perf_addr_o[3:0]];

   always @(posedge clk) begin
      if (load_req) begin
         for (int i = 0; i < 16; i++) cnt[i] <= load_base + 64'(i);
      end else if (perf_we_o) begin
         cnt[perf_addr_o[3:0]] <= perf_data_o;
      end
   end

   // Stream and counter-write monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst && snap_valid_o && snap_ready) begin
         rx_idx.push_back(snap_idx_o);
         rx_data.push_back(snap_data_o);
         rx_last.push_back(snap_last_o);
      end
      if (!rst && perf_we_o) begin
         wr_addr.push_back(perf_addr_o);
         if (perf_data_o != 64'd0) wr_nonzero = 1'b1;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [63:0] base);
      load_base = base;
      load_req  = 1'b1;
      tick();
      load_req  = 1'b0;
   endtask

   task automatic clear_logs;
      rx_idx.delete();
      rx_data.delete();
      rx_last.delete();
      wr_addr.delete();
      wr_nonzero = 1'b0;
   endtask

   task automatic start_snap(input logic clr);
      clear   = clr;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      clear   = 1'b0;
   endtask

   task automatic wait_idle(output int cycles);
      cycles = 0;
      while (busy_o && cycles < 300) begin
         tick();
         cycles++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      n_cmp++; if (busy_o !== 1'b0)          begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_o); end
      n_cmp++; if (snap_valid_o !== 1'b0)    begin n_fail++; $display("FAIL reset_valid got %b want 0", snap_valid_o); end
      n_cmp++; if (perf_we_o !== 1'b0)       begin n_fail++; $display("FAIL reset_we got %b want 0", perf_we_o); end
      n_cmp++; if (perf_addr_o !== 12'd0)    begin n_fail++; $display("FAIL reset_addr got %0d want 0", perf_addr_o); end
      n_cmp++; if (perf_data_o !== 64'd0)    begin n_fail++; $display("FAIL reset_wdata got %0d want 0", perf_data_o); end
      n_cmp++; if (trig_dropped_o !== 1'b0)  begin n_fail++; $display("FAIL reset_dropped got %b want 0", trig_dropped_o); end
   endtask

   task automatic test_basic;
      int cyc;
      load(64'd100);
      clear_logs();
      snap_ready = 1'b1;
      start_snap(1'b0);
      wait_idle(cyc);
      n_cmp++; if (cyc != 15) begin n_fail++; $display("FAIL basic_busy_cycles got %0d want 15", cyc); end
      n_cmp++; if (rx_idx.size() != 14) begin n_fail++; $display("FAIL basic_count got %0d want 14", rx_idx.size()); end
      for (int i = 0; i < rx_idx.size(); i++) begin
         n_cmp++; if (rx_idx[i] !== 4'(i)) begin n_fail++; $display("FAIL basic_idx[%0d] got %0d want %0d", i, rx_idx[i], i); end
         n_cmp++; if (rx_data[i] !== 64'(100 + i)) begin n_fail++; $display("FAIL basic_data[%0d] got %0d want %0d", i, rx_data[i], 100 + i); end
         n_cmp++; if (rx_last[i] !== (i == 13)) begin n_fail++; $display("FAIL basic_last[%0d] got %b want %b", i, rx_last[i], (i == 13)); end
      end
      n_cmp++; if (wr_addr.size() != 0) begin n_fail++; $display("FAIL basic_writes got %0d want 0", wr_addr.size()); end
   endtask

   task automatic test_clear;
      int cyc;
      load(64'd200);
      clear_logs();
      snap_ready = 1'b1;
      start_snap(1'b1);
      wait_idle(cyc);
      n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL clear_timeout busy got %b want 0", busy_o); end
      n_cmp++; if (rx_idx.size() != 14) begin n_fail++; $display("FAIL clear_count got %0d want 14", rx_idx.size()); end
      for (int i = 0; i < rx_data.size(); i++) begin
         n_cmp++; if (rx_data[i] !== 64'(200 + i)) begin n_fail++; $display("FAIL clear_data[%0d] got %0d want %0d", i, rx_data[i], 200 + i); end
      end
      n_cmp++; if (wr_addr.size() != 14) begin n_fail++; $display("FAIL clear_writes got %0d want 14", wr_addr.size()); end
      for (int i = 0; i < wr_addr.size(); i++) begin
         n_cmp++; if (wr_addr[i] !== 12'(i)) begin n_fail++; $display("FAIL clear_waddr[%0d] got %0d want %0d", i, wr_addr[i], i); end
      end
      n_cmp++; if (wr_nonzero !== 1'b0) begin n_fail++; $display("FAIL clear_wdata_nonzero got %b want 0", wr_nonzero); end
      for (int i = 0; i < 14; i++) begin
         n_cmp++; if (cnt[i] !== 64'd0) begin n_fail++; $display("FAIL clear_cnt[%0d] got %0d want 0", i, cnt[i]); end
      end
      n_cmp++; if (cnt[14] !== 64'd214) begin n_fail++; $display("FAIL clear_cnt14 got %0d want 214", cnt[14]); end
   endtask

   task automatic test_stall;
      int cyc;
      load(64'd300);
      clear_logs();
      snap_ready = 1'b0;
      start_snap(1'b0);
      repeat (10) tick();
      n_cmp++; if (perf_addr_o !== 12'd4) begin n_fail++; $display("FAIL stall_addr got %0d want 4", perf_addr_o); end
      n_cmp++; if (perf_we_o !== 1'b0)    begin n_fail++; $display("FAIL stall_we got %b want 0", perf_we_o); end
      n_cmp++; if (snap_valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_valid got %b want 1", snap_valid_o); end
      n_cmp++; if (busy_o !== 1'b1)       begin n_fail++; $display("FAIL stall_busy got %b want 1", busy_o); end
      n_cmp++; if (snap_idx_o !== 4'd0)   begin n_fail++; $display("FAIL stall_head_idx got %0d want 0", snap_idx_o); end
      n_cmp++; if (snap_data_o !== 64'd300) begin n_fail++; $display("FAIL stall_head_data got %0d want 300", snap_data_o); end
      n_cmp++; if (snap_last_o !== 1'b0)  begin n_fail++; $display("FAIL stall_head_last got %b want 0", snap_last_o); end
      snap_ready = 1'b1;
      wait_idle(cyc);
      n_cmp++; if (rx_idx.size() != 14) begin n_fail++; $display("FAIL stall_count got %0d want 14", rx_idx.size()); end
      for (int i = 0; i < rx_idx.size(); i++) begin
         n_cmp++; if (rx_idx[i] !== 4'(i)) begin n_fail++; $display("FAIL stall_idx[%0d] got %0d want %0d", i, rx_idx[i], i); end
         n_cmp++; if (rx_data[i] !== 64'(300 + i)) begin n_fail++; $display("FAIL stall_data[%0d] got %0d want %0d", i, rx_data[i], 300 + i); end
      end
   endtask

   task automatic test_drop;
      int cyc;
      load(64'd500);
      clear_logs();
      snap_ready = 1'b1;
      start_snap(1'b0);
      repeat (3) tick();
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      n_cmp++; if (trig_dropped_o !== 1'b1) begin n_fail++; $display("FAIL drop_flag got %b want 1", trig_dropped_o); end
      n_cmp++; if (busy_o !== 1'b1)         begin n_fail++; $display("FAIL drop_busy got %b want 1", busy_o); end
      wait_idle(cyc);
      repeat (3) tick();
      n_cmp++; if (busy_o !== 1'b0)         begin n_fail++; $display("FAIL drop_restarted busy got %b want 0", busy_o); end
      n_cmp++; if (trig_dropped_o !== 1'b1) begin n_fail++; $display("FAIL drop_sticky got %b want 1", trig_dropped_o); end
      n_cmp++; if (rx_idx.size() != 14)     begin n_fail++; $display("FAIL drop_count got %0d want 14", rx_idx.size()); end
      start_snap(1'b0);
      n_cmp++; if (trig_dropped_o !== 1'b0) begin n_fail++; $display("FAIL drop_cleared got %b want 0", trig_dropped_o); end
      n_cmp++; if (busy_o !== 1'b1)         begin n_fail++; $display("FAIL drop_accept busy got %b want 1", busy_o); end
      wait_idle(cyc);
   endtask

   task automatic test_reset_mid;
      int cyc;
      int k;
      load(64'd400);
      clear_logs();
      snap_ready = 1'b1;
      start_snap(1'b0);
      k = 0;
      while (perf_addr_o != 12'd6 && k < 30) begin
         tick();
         k++;
      end
      n_cmp++; if (perf_addr_o !== 12'd6) begin n_fail++; $display("FAIL rstmid_reach_idx6 got %0d want 6", perf_addr_o); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      n_cmp++; if (busy_o !== 1'b0)       begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy_o); end
      n_cmp++; if (snap_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b want 0", snap_valid_o); end
      n_cmp++; if (perf_addr_o !== 12'd0) begin n_fail++; $display("FAIL rstmid_addr got %0d want 0", perf_addr_o); end
      tick();
      clear_logs();
      start_snap(1'b0);
      wait_idle(cyc);
      n_cmp++; if (rx_idx.size() != 14) begin n_fail++; $display("FAIL rstmid_count got %0d want 14", rx_idx.size()); end
      for (int i = 0; i < rx_idx.size(); i++) begin
         n_cmp++; if (rx_idx[i] !== 4'(i)) begin n_fail++; $display("FAIL rstmid_idx[%0d] got %0d want %0d", i, rx_idx[i], i); end
         n_cmp++; if (rx_data[i] !== 64'(400 + i)) begin n_fail++; $display("FAIL rstmid_data[%0d] got %0d want %0d", i, rx_data[i], 400 + i); end
      end
   endtask

   task automatic test_toggle;
      logic        prev_stall;
      logic [3:0]  prev_idx;
      logic [63:0] prev_data;
      int          k;
      load(64'd700);
      clear_logs();
      snap_ready = 1'b1;
      prev_stall = 1'b0;
      prev_idx   = '0;
      prev_data  = '0;
      start_snap(1'b0);
      k = 0;
      while ((busy_o || snap_valid_o) && k < 300) begin
         @(negedge clk);
         if (prev_stall) begin
            n_cmp++; if (snap_idx_o !== prev_idx) begin n_fail++; $display("FAIL toggle_hold_idx got %0d want %0d", snap_idx_o, prev_idx); end
            n_cmp++; if (snap_data_o !== prev_data) begin n_fail++; $display("FAIL toggle_hold_data got %0d want %0d", snap_data_o, prev_data); end
         end
         prev_stall = snap_valid_o && !snap_ready;
         prev_idx   = snap_idx_o;
         prev_data  = snap_data_o;
         @(posedge clk);
         #1;
         snap_ready = ~snap_ready;
         k++;
      end
      snap_ready = 1'b1;
      n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL toggle_timeout busy got %b want 0", busy_o); end
      n_cmp++; if (rx_idx.size() != 14) begin n_fail++; $display("FAIL toggle_count got %0d want 14", rx_idx.size()); end
      for (int i = 0; i < rx_idx.size(); i++) begin
         n_cmp++; if (rx_idx[i] !== 4'(i)) begin n_fail++; $display("FAIL toggle_idx[%0d] got %0d want %0d", i, rx_idx[i], i); end
         n_cmp++; if (rx_data[i] !== 64'(700 + i)) begin n_fail++; $display("FAIL toggle_data[%0d] got %0d want %0d", i, rx_data[i], 700 + i); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_clear();
      test_stall();
      test_drop();
      test_reset_mid();
      test_toggle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/perf_snapshot.md
PERF_SNAPSHOT -- requirements
Module: perf_snapshot

Interface
REQ-001 SHALL have parameter NR_COUNTERS, default 14, meaning the number of counters scanned per snapshot (range 2..16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the output buffer depth in entries (power of two, ≥2).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_i, input, 1, the reset: synchronous, active-high.
REQ-005 SHALL have port trigger_i, input, 1, a single-cycle snapshot request.
REQ-006 SHALL have port clear_on_read_i, input, 1, sampled with an accepted trigger; when set, each counter is zeroed as it is read.
REQ-007 SHALL have port busy_o, output, 1, high while a snapshot is in progress.
REQ-008 SHALL have port trig_dropped_o, output, 1, a sticky flag: a trigger arrived while busy.
REQ-009 SHALL have port perf_addr_o, output, 12, the counter address to the perf counter SRAM-like port.
REQ-010 SHALL have port perf_we_o, output, 1, the counter write enable.
REQ-011 SHALL have port perf_data_o, output, 64, the counter write data.
REQ-012 SHALL have port perf_data_i, input, 64, the counter read data; it is combinational from perf_addr_o in the same cycle.
REQ-013 SHALL have port snap_valid_o, output, 1, the stream valid.
REQ-014 SHALL have port snap_ready_i, input, 1, the stream ready.
REQ-015 SHALL have port snap_idx_o, output, 4, the counter index of the head entry.
REQ-016 SHALL have port snap_data_o, output, 64, the counter value of the head entry.
REQ-017 SHALL have port snap_last_o, output, 1, marking the entry with index NR_COUNTERS-1.

Function
REQ-018 SHALL implement FSM states IDLE, SCAN and DRAIN.
REQ-019 SHALL, in IDLE, accept trigger_i=1: go to SCAN, set idx=0, latch clear_on_read_i into clr_q, and clear trig_dropped_o.
REQ-020 SHALL, in SCAN with the FIFO not full, drive perf_addr_o={8'b0,idx} and push {idx, perf_data_i, last=(idx==NR_COUNTERS-1)} into the FIFO in that same cycle.
REQ-021 SHALL, in the push cycle with clr_q=1, drive perf_we_o=1 and perf_data_o=0; otherwise perf_we_o=0 and perf_data_o=0.
REQ-022 SHALL, in SCAN with the FIFO full, not push, drive perf_we_o=0, and hold idx and perf_addr_o.
REQ-023 SHALL increment idx after each push; the push at idx==NR_COUNTERS-1 moves the FSM to DRAIN.
REQ-024 SHALL move from DRAIN to IDLE in the cycle after the FIFO becomes empty.
REQ-025 SHALL set busy_o=1 iff the state is not IDLE.
REQ-026 SHALL, on trigger_i=1 with busy_o=1, ignore the trigger and set trig_dropped_o=1 until the next accepted trigger.
REQ-027 SHALL make the stream a valid/ready FIFO: snap_valid_o = FIFO not empty; a pop occurs when snap_valid_o and snap_ready_i are both high.
REQ-028 SHALL keep the head entry's fields stable while snap_valid_o=1 and snap_ready_i=0.
REQ-029 SHALL, when a push and a pop occur in the same cycle on a full FIFO, treat the FIFO as full at push time; the push is stalled.
REQ-030 SHALL, when a push and a pop occur in the same cycle on a non-full FIFO, complete both and leave the occupancy unchanged.
REQ-031 SHALL give a minimum snapshot latency of NR_COUNTERS SCAN cycles, with the first entry visible on snap_valid_o one cycle after its push.
REQ-032 SHALL, when perf_we_o=0, drive perf_addr_o to the current idx in SCAN and 0 otherwise.

Reset
REQ-033 SHALL, with rst_i=1 at a clock edge, set state=IDLE, idx=0, clr_q=0, FIFO empty and trig_dropped_o=0.
REQ-034 SHALL drive outputs in reset as busy_o=0, snap_valid_o=0, perf_we_o=0, perf_addr_o=0 and perf_data_o=0.
REQ-035 SHALL abort any in-progress snapshot on reset mid-scan and discard all buffered entries; counters already cleared stay cleared.

Verification
REQ-036 SHALL pass: trigger with clear=0, ready held 1, counters hold 100+i → 14 entries with idx 0..13, data 100..113, last only on idx 13, no writes, busy for 15 cycles.
REQ-037 SHALL pass: trigger with clear=1 → each counter is written 0 in its read cycle, and the entries carry the pre-clear values.
REQ-038 SHALL pass: ready held 0 after trigger → exactly 4 pushes, perf_addr_o stalls at 4; after ready rises, the remaining entries arrive in order and none are lost.
REQ-039 SHALL pass: second trigger during SCAN → ignored and trig_dropped_o=1; the next trigger accepted from IDLE clears the flag.
REQ-040 SHALL pass: rst_i asserted at idx=6 → the next cycle shows busy_o=0 and snap_valid_o=0; a new trigger restarts from idx 0.
REQ-041 SHALL pass: ready toggling 1/0 each cycle → the stream holds stable data while stalled and the order is preserved.
